// File: rtl/tran_pkg.sv
// Shared types and constants for the 4x4 forward-transform macroblock controller.
package tran_pkg;

   localparam int DEF_COEF_W = 32;
   localparam int BLK_PER_MB = 16;
   localparam logic [3:0] LAST_BLK = 4'(BLK_PER_MB - 1);

   typedef logic signed [7:0] res_t;
   typedef res_t [15:0] res_blk_t;

   typedef logic signed [DEF_COEF_W-1:0] coef_t;
   typedef coef_t [15:0] coef_blk_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_OUT   = 2'd2
   } state_e;

endpackage

// File: rtl/tran_dc_buf.sv
// DC coefficient collector for the Intra16x16 Hadamard stage.
// Built only when TRAN_DC_COLLECT_EN is defined.
`ifdef TRAN_DC_COLLECT_EN
module tran_dc_buf
   import tran_pkg::*;
#(
   parameter int COEF_W = DEF_COEF_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [3:0]              wr_idx,
   input  logic [COEF_W-1:0]       wr_data,
   input  logic                    clear,
   output logic                    dc_valid,
   output logic [15:0][COEF_W-1:0] dc_coeffs
);

   logic [15:0][COEF_W-1:0] dc_buf_q, dc_buf_d;
   logic [15:0][COEF_W-1:0] out_q, out_d;
   logic [15:0]             vld_q, vld_d;
   logic                    pulse_q, pulse_d;

   // The output snapshot is taken on block 15 so it stays put while the next MB refills dc_buf_q.
   always_comb begin
      dc_buf_d = dc_buf_q;
      vld_d    = vld_q;
      out_d    = out_q;
      pulse_d  = 1'b0;
      if (clear) begin
         vld_d = '0;
      end else if (wr_en) begin
         dc_buf_d[wr_idx] = wr_data;
         vld_d[wr_idx]    = 1'b1;
         if (wr_idx == LAST_BLK) begin
            vld_d = '0;
            if (&vld_q[14:0]) begin
               out_d   = {wr_data, dc_buf_q[14:0]};
               pulse_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dc_buf_q <= '0;
         vld_q    <= '0;
         out_q    <= '0;
         pulse_q  <= 1'b0;
      end else begin
         dc_buf_q <= dc_buf_d;
         vld_q    <= vld_d;
         out_q    <= out_d;
         pulse_q  <= pulse_d;
      end
   end

   assign dc_valid  = pulse_q;
   assign dc_coeffs = out_q;

endmodule
`endif

// File: rtl/tran_mb_ctrl.sv
// Sequences a 4x4 forward transform over the 16 blocks of a luma macroblock.
// Optional DC collection (dc_valid/dc_coeffs) is enabled by defining TRAN_DC_COLLECT_EN.
//
// state    | meaning
// ST_IDLE  | waiting for a residual block, in_ready high
// ST_ISSUE | tr_enable pulse, transform computing
// ST_OUT   | coefficients presented until the quantiser takes them
module tran_mb_ctrl
   import tran_pkg::*;
#(
   parameter int COEF_W   = DEF_COEF_W,
   parameter int MB_CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  res_blk_t                in_residuals,
   input  logic                    mb_abort,
   output logic                    tr_enable,
   output res_blk_t                tr_residuals,
   input  logic [15:0][COEF_W-1:0] tr_transformed,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [15:0][COEF_W-1:0] out_coeffs,
   output logic [3:0]              out_blk_idx,
   output logic                    out_mb_last,
   output logic [MB_CNT_W-1:0]     mb_count
`ifdef TRAN_DC_COLLECT_EN
   ,
   output logic                    dc_valid,
   output logic [15:0][COEF_W-1:0] dc_coeffs
`endif
);

   state_e              state_q, state_d;
   logic [3:0]          blk_cnt_q, blk_cnt_d;
   logic [MB_CNT_W-1:0] mb_count_q, mb_count_d;
   res_blk_t            tr_res_q, tr_res_d;
   logic                accept;
   logic                out_hs;

   assign accept = in_valid && in_ready;
   assign out_hs = (state_q == ST_OUT) && out_ready && !mb_abort;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_OUT;
         ST_OUT:   if (out_ready) state_d = accept ? ST_ISSUE : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (mb_abort) state_d = ST_IDLE;
   end

   // Abort masks in_ready so a block offered in the abort cycle is never latched.
   always_comb begin
      in_ready    = 1'b0;
      tr_enable   = 1'b0;
      out_valid   = 1'b0;
      out_mb_last = 1'b0;
      case (state_q)
         ST_IDLE:  in_ready = !mb_abort;
         ST_ISSUE: tr_enable = 1'b1;
         ST_OUT: begin
            out_valid   = 1'b1;
            out_mb_last = (blk_cnt_q == LAST_BLK);
            in_ready    = out_ready && !mb_abort;
         end
         default: ;
      endcase
   end

   always_comb begin
      blk_cnt_d  = blk_cnt_q;
      mb_count_d = mb_count_q;
      tr_res_d   = tr_res_q;
      if (accept) tr_res_d = in_residuals;
      if (mb_abort) begin
         blk_cnt_d = '0;
      end else if (out_hs) begin
         blk_cnt_d = blk_cnt_q + 4'd1;
         if (blk_cnt_q == LAST_BLK) mb_count_d = mb_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blk_cnt_q  <= '0;
         mb_count_q <= '0;
         tr_res_q   <= '0;
      end else begin
         blk_cnt_q  <= blk_cnt_d;
         mb_count_q <= mb_count_d;
         tr_res_q   <= tr_res_d;
      end
   end

   assign tr_residuals = tr_res_q;
   assign out_coeffs   = tr_transformed;
   assign out_blk_idx  = blk_cnt_q;
   assign mb_count     = mb_count_q;

`ifdef TRAN_DC_COLLECT_EN
   tran_dc_buf #(.COEF_W(COEF_W)) u_dc_buf (
      .clk       (clk),
      .rst_n     (reset),
      .wr_en     (out_hs),
      .wr_idx    (blk_cnt_q),
      .wr_data   (tr_transformed[0]),
      .clear     (mb_abort),
      .dc_valid  (dc_valid),
      .dc_coeffs (dc_coeffs)
   );
`endif

endmodule

// File: tb/tb_tran_mb_ctrl.sv
// Bench for tran_mb_ctrl: behavioural 4x4 transform, table of MB vectors, scoreboard queue.
// DC collection checks are included when TRAN_DC_COLLECT_EN is defined.
module tb_tran_mb_ctrl;
   import tran_pkg::*;

   localparam int CW = 32;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   res_blk_t            in_residuals;
   logic                mb_abort;
   logic                tr_enable;
   res_blk_t            tr_residuals;
   logic [15:0][CW-1:0] tr_transformed;
   logic                out_valid;
   logic                out_ready;
   logic [15:0][CW-1:0] out_coeffs;
   logic [3:0]          out_blk_idx;
   logic                out_mb_last;
   logic [15:0]         mb_count;
`ifdef TRAN_DC_COLLECT_EN
   logic                dc_valid;
   logic [15:0][CW-1:0] dc_coeffs;
`endif

   tran_mb_ctrl #(.COEF_W(CW), .MB_CNT_W(16)) dut (
      .clk            (clk),
      .reset          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_residuals   (in_residuals),
      .mb_abort       (mb_abort),
      .tr_enable      (tr_enable),
      .tr_residuals   (tr_residuals),
      .tr_transformed (tr_transformed),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_coeffs     (out_coeffs),
      .out_blk_idx    (out_blk_idx),
      .out_mb_last    (out_mb_last),
      .mb_count       (mb_count)
`ifdef TRAN_DC_COLLECT_EN
      ,
      .dc_valid       (dc_valid),
      .dc_coeffs      (dc_coeffs)
`endif
   );

   always #5 clk = ~clk;

   // Y = C * X * C^T with the standard 4x4 forward integer core matrix.
   function automatic logic [15:0][CW-1:0] fwd4x4(input res_blk_t r);
      int x[4][4];
      int t[4][4];
      int c[4][4];
      int s;
      logic [15:0][CW-1:0] y;
      c = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            x[i][j] = int'($signed(r[i*4+j]));
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += c[i][k] * x[k][j];
            t[i][j] = s;
         end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += t[i][k] * c[j][k];
            y[i*4+j] = CW'(s);
         end
      return y;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)         tr_transformed <= '0;
      else if (tr_enable) tr_transformed <= fwd4x4(tr_residuals);
   end

   typedef struct {
      logic [15:0][CW-1:0] c;
      logic [CW-1:0]       c0;
      logic [3:0]          idx;
      logic                last;
   } exp_t;

   typedef struct {
      res_blk_t   res;
      logic [3:0] idx;
      logic       last;
      int         c0;
   } vec_t;

   exp_t sbq[$];
   vec_t tbl[16];
   int   checks = 0;
   int   errors = 0;
   bit   gap_chk = 1'b0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: scoreboard pops on handshake, enable/handshake alternation, handshake spacing.
   int  enables_since_hs = 0;
   bit  gap_armed = 1'b0;
   time last_hs = 0;
`ifdef TRAN_DC_COLLECT_EN
   bit  hs15_prev = 1'b0;
   int  dc_pulses = 0;
`endif
   always @(negedge clk) begin
      exp_t e;
      bit   hs;
      if (!rst_n) begin
         enables_since_hs = 0;
         gap_armed = 1'b0;
      end else begin
         hs = out_valid && out_ready && !mb_abort;
         if (tr_enable) begin
            chk("enable_once", 512'(enables_since_hs), 512'd0);
            chk("enable_vs_out_valid", 512'(out_valid), 512'd0);
            enables_since_hs++;
         end
         if (mb_abort) enables_since_hs = 0;
`ifdef TRAN_DC_COLLECT_EN
         if (hs15_prev || dc_valid) chk("dc_valid_timing", 512'(dc_valid), 512'(hs15_prev));
         if (dc_valid) dc_pulses++;
         hs15_prev = hs && (out_blk_idx == 4'd15);
`endif
         if (hs) begin
            enables_since_hs = 0;
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_output actual=idx%0d required=no_output", out_blk_idx);
            end else begin
               e = sbq.pop_front();
               chk("sb_coeffs", 512'(out_coeffs), 512'(e.c));
               chk("sb_coef0", 512'(out_coeffs[0]), 512'(e.c0));
               chk("sb_blk_idx", 512'(out_blk_idx), 512'(e.idx));
               chk("sb_mb_last", 512'(out_mb_last), 512'(e.last));
            end
            if (gap_chk && gap_armed) chk("hs_spacing", 512'($time - last_hs), 512'd20);
            gap_armed = gap_chk;
            last_hs = $time;
         end
      end
   end

   task automatic send_blk(input res_blk_t r, input logic [3:0] idx);
      exp_t e;
      bit   acc;
      acc = 1'b0;
      in_residuals = r;
      in_valid = 1'b1;
      for (int n = 0; n < 50 && !acc; n++) begin
         #1;
         acc = in_ready;
         step();
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=not_accepted required=accepted idx=%0d", idx);
      end else begin
         e.c = fwd4x4(r);
         e.c0 = e.c[0];
         e.idx = idx;
         e.last = (idx == 4'd15);
         sbq.push_back(e);
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 40 && sbq.size() != 0; n++) step();
      chk("drain_queue_empty", 512'(sbq.size()), 512'd0);
   endtask

   function automatic res_blk_t rnd_blk();
      res_blk_t r;
      for (int i = 0; i < 16; i++) r[i] = res_t'($urandom_range(0, 255));
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      res_blk_t            r;
      res_blk_t            ones;
      logic [15:0][CW-1:0] exp_c;

      for (int k = 0; k < 16; k++) begin
         tbl[k].res = '0;
         tbl[k].res[0] = res_t'(k);
         tbl[k].idx = 4'(k);
         tbl[k].last = (k == 15);
         tbl[k].c0 = k;
      end
      for (int i = 0; i < 16; i++) ones[i] = 8'sd1;

      in_valid = 1'b0;
      in_residuals = '0;
      out_ready = 1'b1;
      mb_abort = 1'b0;
      rst_n = 1'b0;
      #12;
      chk("rst_tr_enable", 512'(tr_enable), 512'd0);
      chk("rst_out_valid", 512'(out_valid), 512'd0);
      chk("rst_tr_residuals", 512'(tr_residuals), 512'd0);
      chk("rst_out_blk_idx", 512'(out_blk_idx), 512'd0);
      chk("rst_out_mb_last", 512'(out_mb_last), 512'd0);
      chk("rst_mb_count", 512'(mb_count), 512'd0);
      chk("rst_in_ready", 512'(in_ready), 512'd1);
`ifdef TRAN_DC_COLLECT_EN
      chk("rst_dc_valid", 512'(dc_valid), 512'd0);
      chk("rst_dc_coeffs", 512'(dc_coeffs), 512'd0);
`endif
      #5;
      rst_n = 1'b1;
      step();

      // Single block of ones
      send_blk(ones, 4'd0);
      in_valid = 1'b0;
      chk("t1_tr_enable_issue", 512'(tr_enable), 512'd1);
      chk("t1_out_valid_issue", 512'(out_valid), 512'd0);
      chk("t1_in_ready_issue", 512'(in_ready), 512'd0);
      chk("t1_tr_residuals", 512'(tr_residuals), 512'(ones));
      step();
      chk("t1_tr_enable_out", 512'(tr_enable), 512'd0);
      chk("t1_out_valid", 512'(out_valid), 512'd1);
      chk("t1_out_coeffs", 512'(out_coeffs), 512'd16);
      chk("t1_out_blk_idx", 512'(out_blk_idx), 512'd0);
      step();
      chk("t1_out_valid_after", 512'(out_valid), 512'd0);
      chk("t1_queue_empty", 512'(sbq.size()), 512'd0);

      // Abort in IDLE clears the block counter without touching mb_count
      mb_abort = 1'b1;
      #1;
      chk("abort_idle_in_ready", 512'(in_ready), 512'd0);
      step();
      mb_abort = 1'b0;
      chk("abort_idle_blk_idx", 512'(out_blk_idx), 512'd0);

      // Full macroblock, back to back
      gap_chk = 1'b1;
      for (int k = 0; k < 16; k++) send_blk(tbl[k].res, tbl[k].idx);
      in_valid = 1'b0;
      drain();
      gap_chk = 1'b0;
      chk("mb_full_mb_count", 512'(mb_count), 512'd1);
      chk("mb_full_blk_idx_wrap", 512'(out_blk_idx), 512'd0);
      for (int k = 0; k < 16; k++) begin
         chk("tbl_last_flag", 512'(tbl[k].last), 512'(k == 15));
      end
`ifdef TRAN_DC_COLLECT_EN
      chk("dc_pulse_count", 512'(dc_pulses), 512'd1);
      for (int k = 0; k < 16; k++) chk("dc_coeff", 512'(dc_coeffs[k]), 512'(tbl[k].c0));
`endif

      // Backpressure: hold OUT for five cycles
      out_ready = 1'b0;
      r = rnd_blk();
      exp_c = fwd4x4(r);
      send_blk(r, 4'd0);
      in_valid = 1'b0;
      step();
      for (int n = 0; n < 5; n++) begin
         chk("bp_out_valid", 512'(out_valid), 512'd1);
         chk("bp_out_coeffs", 512'(out_coeffs), 512'(exp_c));
         chk("bp_blk_idx", 512'(out_blk_idx), 512'd0);
         chk("bp_in_ready", 512'(in_ready), 512'd0);
         chk("bp_tr_enable", 512'(tr_enable), 512'd0);
         step();
      end
      out_ready = 1'b1;
      step();
      chk("bp_out_valid_after", 512'(out_valid), 512'd0);
      chk("bp_queue_empty", 512'(sbq.size()), 512'd0);

      // Abort while block 7 is waiting in OUT
      for (int k = 1; k < 7; k++) send_blk(rnd_blk(), 4'(k));
      in_valid = 1'b0;
      drain();
      out_ready = 1'b0;
      send_blk(rnd_blk(), 4'd7);
      in_valid = 1'b0;
      step();
      chk("ab_out_valid", 512'(out_valid), 512'd1);
      chk("ab_blk_idx", 512'(out_blk_idx), 512'd7);
      out_ready = 1'b1;
      mb_abort = 1'b1;
      #1;
      chk("ab_in_ready", 512'(in_ready), 512'd0);
      step();
      mb_abort = 1'b0;
      if (sbq.size() != 0) void'(sbq.pop_back());
      chk("ab_out_valid_after", 512'(out_valid), 512'd0);
      chk("ab_blk_idx_after", 512'(out_blk_idx), 512'd0);
      chk("ab_mb_count", 512'(mb_count), 512'd1);
      send_blk(rnd_blk(), 4'd0);
      in_valid = 1'b0;
      drain();

      // Asynchronous reset during ISSUE
      send_blk(rnd_blk(), 4'd1);
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("rr_tr_enable", 512'(tr_enable), 512'd0);
      chk("rr_out_valid", 512'(out_valid), 512'd0);
      chk("rr_tr_residuals", 512'(tr_residuals), 512'd0);
      chk("rr_blk_idx", 512'(out_blk_idx), 512'd0);
      chk("rr_mb_count", 512'(mb_count), 512'd0);
      chk("rr_mb_last", 512'(out_mb_last), 512'd0);
      sbq.delete();
      #3;
      rst_n = 1'b1;
      step();
      send_blk(rnd_blk(), 4'd0);
      in_valid = 1'b0;
      drain();
      chk("rr_mb_count_after", 512'(mb_count), 512'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
